// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: controller state
// encoding and default operand sizing.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 4;

    // Encoding is fixed so external checkers can decode the state vector.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/somador_nbits.sv
// Purely combinational WIDTH-bit ripple-carry adder.
// It is built from a chain of 1-bit full adders.
module somador_nbits #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/mult_shift_add_8bits.sv
// Sequential unsigned shift-and-add multiplier: one adder pass per clock,
// WIDTH iterations per product, with a start/busy/done handshake.
module mult_shift_add_8bits
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // Handshake: start is sampled only while idle (busy=0); the edge that
    // sees start=1 in IDLE accepts a/b. done is a one-cycle pulse marking
    // product valid; product then holds until the next accepted operation.

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic [2*WIDTH-1:0] product_r;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             last_iter;

    assign addend    = acc_lo[0] ? mcand : '0;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    somador_nbits #(
        .WIDTH (WIDTH)
    ) u_somador (
        .x    (acc_hi),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The adder carry becomes the MSB of the right-shifted accumulator,
    // so no bit of the partial sum is ever dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            cnt       <= '0;
            product_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        cnt    <= '0;
                    end
                end
                S_CALC: begin
                    acc_hi <= {cout, sum[WIDTH-1:1]};
                    acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        product_r <= {cout, sum, acc_lo[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign product = product_r;

endmodule

// File: tb/tb_mult_shift_add_8bits.sv
// Self-checking bench for mult_shift_add_8bits: directed cases, async reset
// abort, held-start retrigger and a random sweep against a queued a*b model.
module tb_mult_shift_add_8bits;

    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] hold_val;
    logic           prev_done;

    mult_shift_add_8bits #(
        .WIDTH (W),
        .CNT_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: pop on every done pulse, otherwise product must hold
    always @(negedge clk) begin
        if (rst) begin
            hold_val  = '0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("product", 32'(product), 32'(exp_q.pop_front()));
                end
                hold_val = product;
            end else begin
                chk("product_hold", 32'(product), 32'(hold_val));
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (busy) chk("idle_wait_timeout", 32'd1, 32'd0);
    endtask

    // drive one multiply, check busy and done latency
    task automatic run_one(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        int lat;
        wait_idle();
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        exp_q.push_back(16'(ta) * 16'(tb_v));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("done_latency", 32'(lat), 32'd9);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // basic, carry path, zero and identity
        run_one(8'h0F, 8'h0F);
        run_one(8'hFF, 8'hFF);
        run_one(8'h80, 8'h02);
        run_one(8'h00, 8'h55);
        run_one(8'h37, 8'h01);

        // start during CALC is ignored; held start retriggers after DONE
        wait_idle();
        a = 8'h03; b = 8'h05; start = 1'b1;
        exp_q.push_back(16'h000F);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1;
        exp_q.push_back(16'h03A8);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("first_done_seen", 32'(done), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
        chk("retrigger_period", 32'(n), 32'd10);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_retrigger", 32'(busy), 32'd0);

        // async reset mid-CALC discards the operation
        wait_idle();
        a = 8'h5A; b = 8'hC3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("busy_before_abort", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_product", 32'(product), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        run_one(8'h0A, 8'h0B);

        // random sweep
        for (int i = 0; i < 1000; i++) begin
            run_one(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

endmodule
